// File: rtl/sub_64bit_if.sv
// Operand/result handshake bundle for sub_64bit_seq.
// The zero/negative flags exist only when SUB_FLAGS_EN is defined.
interface sub_64bit_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        overflow;
    logic        borrow;
`ifdef SUB_FLAGS_EN
    logic        zero;
    logic        negative;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, overflow, borrow, zero, negative
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, overflow, borrow, zero, negative
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, overflow, borrow
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, overflow, borrow
    );
`endif
endinterface

// File: rtl/sub_64bit_seq.sv
// Sequential 64-bit signed subtractor: a + ~b + 1 computed SLICE_W bits per cycle.
// Defining SUB_FLAGS_EN adds registered zero/negative result flags.
module sub_64bit_seq #(
    parameter int SLICE_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    sub_64bit_if.slave bus
);
    localparam int NUM_SLICES = 64 / SLICE_W;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [63:0]        a_r;
    logic [63:0]        nb_r;
    logic [63:0]        diff_r;
    logic               carry_r;
    logic [CNT_W-1:0]   count_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               overflow_r;
    logic               borrow_r;
`ifdef SUB_FLAGS_EN
    logic               zero_r;
    logic               negative_r;
`endif

    logic [5:0]         base_s;
    logic [SLICE_W-1:0] a_slice_s;
    logic [SLICE_W-1:0] nb_slice_s;
    logic [SLICE_W:0]   sum_s;
    logic [63:0]        diff_next_s;
    logic               ovf_next_s;

    function automatic logic [SLICE_W:0] slice_add(
        input logic [SLICE_W-1:0] x,
        input logic [SLICE_W-1:0] y,
        input logic               cin
    );
        return {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, cin};
    endfunction

    // Slice adder datapath and the full diff/overflow as they will look after this edge
    always_comb begin
        base_s      = 6'(count_r) * 6'(SLICE_W);
        a_slice_s   = a_r[base_s +: SLICE_W];
        nb_slice_s  = nb_r[base_s +: SLICE_W];
        sum_s       = slice_add(a_slice_s, nb_slice_s, carry_r);
        diff_next_s = diff_r;
        diff_next_s[base_s +: SLICE_W] = sum_s[SLICE_W-1:0];
        // carry into bit 63 is recovered from the sum bit; only meaningful on the last slice
        ovf_next_s  = a_r[63] ^ nb_r[63] ^ diff_next_s[63] ^ sum_s[SLICE_W];
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= 64'd0;
            nb_r        <= 64'd0;
            diff_r      <= 64'd0;
            carry_r     <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            borrow_r    <= 1'b0;
`ifdef SUB_FLAGS_EN
            zero_r      <= 1'b0;
            negative_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_r        <= bus.a;
                        nb_r       <= ~bus.b;
                        carry_r    <= 1'b1;
                        count_r    <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= CALC;
                    end
                end
                CALC: begin
                    diff_r  <= diff_next_s;
                    carry_r <= sum_s[SLICE_W];
                    if (count_r == LAST_CNT) begin
                        overflow_r  <= ovf_next_s;
                        borrow_r    <= ~sum_s[SLICE_W];
`ifdef SUB_FLAGS_EN
                        zero_r      <= (diff_next_s == 64'd0);
                        negative_r  <= diff_next_s[63];
`endif
                        count_r     <= {CNT_W{1'b0}};
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    count_r     <= {CNT_W{1'b0}};
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.diff      = diff_r;
    assign bus.overflow  = overflow_r;
    assign bus.borrow    = borrow_r;
`ifdef SUB_FLAGS_EN
    assign bus.zero      = zero_r;
    assign bus.negative  = negative_r;
`endif

endmodule

// File: tb/tb_sub_64bit_seq.sv
// Randomized self-checking bench for sub_64bit_seq: directed cases on SLICE_W=8,
// then 1000 random pairs each on SLICE_W = 1, 8 and 64 against an arithmetic model.
module tb_sub_64bit_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk;
    int   n_err;
    logic sweep_go;
    int   sweep_done;

    always #5 clk = ~clk;

    sub_64bit_if dbus ();
    sub_64bit_seq #(.SLICE_W(8)) u_dut (.clk(clk), .rst_n(rst_n), .bus(dbus));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // {overflow, borrow, diff} from plain wide signed/unsigned arithmetic
    function automatic logic [65:0] ref_sub(input logic [63:0] x, input logic [63:0] y);
        logic signed [64:0] wide;
        wide = $signed({x[63], x}) - $signed({y[63], y});
        return {wide[64] != wide[63], x < y, x - y};
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'h8000_0000_0000_0000;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic d_op(input string tag, input logic [63:0] ra, input logic [63:0] rb);
        logic [65:0] ev;
        int          lat;
        ev = ref_sub(ra, rb);
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(dbus.in_ready), 64'd1);
        dbus.a        = ra;
        dbus.b        = rb;
        dbus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        dbus.in_valid = 1'b0;
        dbus.a        = ~ra;
        dbus.b        = ra;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!dbus.out_valid && lat < 200);
        chk({tag, "_latency"}, 64'(lat), 64'd8);
        chk({tag, "_diff"}, dbus.diff, ev[63:0]);
        chk({tag, "_overflow"}, 64'(dbus.overflow), 64'(ev[65]));
        chk({tag, "_borrow"}, 64'(dbus.borrow), 64'(ev[64]));
`ifdef SUB_FLAGS_EN
        chk({tag, "_zero"}, 64'(dbus.zero), 64'(ev[63:0] == 64'd0));
        chk({tag, "_negative"}, 64'(dbus.negative), 64'(ev[63]));
`endif
        dbus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        dbus.out_ready = 1'b0;
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int SW = (g == 0) ? 1 : ((g == 1) ? 8 : 64);
        sub_64bit_if sbus ();
        sub_64bit_seq #(.SLICE_W(SW)) u_sdut (.clk(clk), .rst_n(rst_n), .bus(sbus));

        initial begin
            int          lat;
            logic [63:0] ra;
            logic [63:0] rb;
            logic [65:0] ev;
            sbus.in_valid  = 1'b0;
            sbus.out_ready = 1'b0;
            sbus.a         = 64'd0;
            sbus.b         = 64'd0;
            wait (sweep_go);
            for (int i = 0; i < 1000; i++) begin
                ra = rnd64();
                rb = ($urandom_range(0, 15) == 0) ? ra : rnd64();
                ev = ref_sub(ra, rb);
                @(negedge clk);
                sbus.a        = ra;
                sbus.b        = rb;
                sbus.in_valid = 1'b1;
                @(posedge clk);
                #1;
                sbus.in_valid = 1'b0;
                sbus.a        = ~ra;
                sbus.b        = ~rb;
                lat = 0;
                do begin
                    @(posedge clk);
                    lat++;
                    #1;
                end while (!sbus.out_valid && lat < 200);
                chk($sformatf("sw%0d_latency", SW), 64'(lat), 64'(64 / SW));
                chk($sformatf("sw%0d_diff", SW), sbus.diff, ev[63:0]);
                chk($sformatf("sw%0d_overflow", SW), 64'(sbus.overflow), 64'(ev[65]));
                chk($sformatf("sw%0d_borrow", SW), 64'(sbus.borrow), 64'(ev[64]));
                sbus.out_ready = 1'b1;
                @(posedge clk);
                #1;
                sbus.out_ready = 1'b0;
            end
            sweep_done++;
        end
    end

    initial begin
        logic [63:0] x;
        int          lat;
        n_chk          = 0;
        n_err          = 0;
        sweep_go       = 1'b0;
        sweep_done     = 0;
        dbus.in_valid  = 1'b0;
        dbus.out_ready = 1'b0;
        dbus.a         = 64'd0;
        dbus.b         = 64'd0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(dbus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(dbus.out_valid), 64'd0);
        chk("rst_diff", dbus.diff, 64'd0);
        chk("rst_overflow", 64'(dbus.overflow), 64'd0);
        chk("rst_borrow", 64'(dbus.borrow), 64'd0);
`ifdef SUB_FLAGS_EN
        chk("rst_zero", 64'(dbus.zero), 64'd0);
        chk("rst_negative", 64'(dbus.negative), 64'd0);
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        d_op("basic", 64'd100, 64'd58);
        d_op("min_minus_1", 64'h8000_0000_0000_0000, 64'd1);
        d_op("zero_minus_min", 64'd0, 64'h8000_0000_0000_0000);
        d_op("borrow", 64'd3, 64'd5);
        x = {$urandom(), $urandom()};
        d_op("self", x, x);

        // Backpressure: result held while a second request waits
        @(negedge clk);
        dbus.a        = 64'd7;
        dbus.b        = 64'd2;
        dbus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        dbus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!dbus.out_valid && lat < 200);
        chk("bp_latency", 64'(lat), 64'd8);
        @(negedge clk);
        dbus.a        = 64'd1000;
        dbus.b        = 64'd1;
        dbus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_diff", dbus.diff, 64'd5);
            chk("bp_hold_flags", {62'd0, dbus.overflow, dbus.borrow}, 64'd0);
            chk("bp_hold_out_valid", 64'(dbus.out_valid), 64'd1);
            chk("bp_hold_in_ready", 64'(dbus.in_ready), 64'd0);
        end
        dbus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        dbus.out_ready = 1'b0;
        chk("bp_release_in_ready", 64'(dbus.in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(dbus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        dbus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!dbus.out_valid && lat < 200);
        chk("bp_second_latency", 64'(lat), 64'd8);
        chk("bp_second_diff", dbus.diff, 64'd999);
        dbus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        dbus.out_ready = 1'b0;

        // Reset after three slices have been processed
        @(negedge clk);
        dbus.a        = rnd64();
        dbus.b        = rnd64();
        dbus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        dbus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rmid_out_valid", 64'(dbus.out_valid), 64'd0);
        chk("rmid_in_ready", 64'(dbus.in_ready), 64'd1);
        chk("rmid_diff", dbus.diff, 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rmid_no_result", 64'(dbus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        d_op("after_reset", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);

        sweep_go = 1'b1;
        for (int c = 0; c < 90000 && sweep_done < 3; c++) @(negedge clk);
        chk("sweep_done", 64'(sweep_done), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
